// File: rtl/mem_dump_streamer.sv
// Reads a contiguous range of BRAM blocks word by word and emits one framed byte stream
// per block (0xA5, block index, words MSB first, XOR checksum) over a valid/ready byte port.
module mem_dump_streamer #(
    parameter int MEM_SELECT_BITS = 5,
    parameter int ADDR_BITS       = 8,
    parameter int DATA_BITS       = 16,
    parameter int NUM_BLOCKS      = 30,
    parameter int RD_LATENCY      = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [MEM_SELECT_BITS-1:0] first_block,
    input  logic [MEM_SELECT_BITS-1:0] last_block,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [MEM_SELECT_BITS-1:0] mem_select,
    output logic [ADDR_BITS-1:0]       mem_addr,
    output logic                       rd_en,
    input  logic [DATA_BITS-1:0]       mem_out,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready
);

    localparam int LAT_W = 2;
    localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(RD_LATENCY - 1);
    // One extra bit so a block count equal to 2**MEM_SELECT_BITS is still representable.
    localparam logic [MEM_SELECT_BITS:0] NUM_BLOCKS_W = (MEM_SELECT_BITS + 1)'(NUM_BLOCKS);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC,
        S_BIDX,
        S_RD,
        S_WAIT,
        S_HI,
        S_LO,
        S_CKS,
        S_FIN
    } state_t;

    state_t                     state_reg, state_next;
    logic [MEM_SELECT_BITS-1:0] mem_select_reg, mem_select_next;
    logic [MEM_SELECT_BITS-1:0] last_reg, last_next;
    logic [ADDR_BITS-1:0]       mem_addr_reg, mem_addr_next;
    logic [DATA_BITS-1:0]       word_reg, word_next;
    logic [7:0]                 cks_reg, cks_next;
    logic [LAT_W-1:0]           lat_reg, lat_next;
    logic                       err_reg, err_next;

    logic [7:0] bidx_byte;
    logic       range_bad;

    // Block index zero-extended to one byte.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bidx
            if (gi < MEM_SELECT_BITS) begin : g_bit
                assign bidx_byte[gi] = mem_select_reg[gi];
            end else begin : g_zero
                assign bidx_byte[gi] = 1'b0;
            end
        end
    endgenerate

    assign range_bad = (first_block > last_block) ||
                       ({1'b0, last_block} >= NUM_BLOCKS_W);

    assign mem_select = mem_select_reg;
    assign mem_addr   = mem_addr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            mem_select_reg <= '0;
            last_reg       <= '0;
            mem_addr_reg   <= '0;
            word_reg       <= '0;
            cks_reg        <= '0;
            lat_reg        <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mem_select_reg <= mem_select_next;
            last_reg       <= last_next;
            mem_addr_reg   <= mem_addr_next;
            word_reg       <= word_next;
            cks_reg        <= cks_next;
            lat_reg        <= lat_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        mem_select_next = mem_select_reg;
        last_next       = last_reg;
        mem_addr_next   = mem_addr_reg;
        word_next       = word_reg;
        cks_next        = cks_reg;
        lat_next        = lat_reg;
        err_next        = err_reg;
        busy            = 1'b0;
        done            = 1'b0;
        err             = 1'b0;
        rd_en           = 1'b0;
        tx_valid        = 1'b0;
        tx_data         = 8'h00;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (range_bad) begin
                        err_next   = 1'b1;
                        state_next = S_FIN;
                    end else begin
                        err_next        = 1'b0;
                        last_next       = last_block;
                        mem_select_next = first_block;
                        mem_addr_next   = '0;
                        cks_next        = 8'h00;
                        state_next      = S_SYNC;
                    end
                end
            end
            S_SYNC: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) state_next = S_BIDX;
            end
            S_BIDX: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = bidx_byte;
                if (tx_ready) state_next = S_RD;
            end
            S_RD: begin
                busy       = 1'b1;
                rd_en      = 1'b1;
                lat_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // Address stays parked here so the BRAM output is valid on the final count.
                if (lat_reg == LAST_LAT) begin
                    word_next  = mem_out;
                    cks_next   = cks_reg ^ mem_out[DATA_BITS-1:8] ^ mem_out[7:0];
                    state_next = S_HI;
                end else begin
                    lat_next = lat_reg + 1'b1;
                end
            end
            S_HI: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = word_reg[DATA_BITS-1:8];
                if (tx_ready) state_next = S_LO;
            end
            S_LO: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = word_reg[7:0];
                if (tx_ready) begin
                    if (mem_addr_reg == '1) begin
                        state_next = S_CKS;
                    end else begin
                        mem_addr_next = mem_addr_reg + 1'b1;
                        state_next    = S_RD;
                    end
                end
            end
            S_CKS: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = cks_reg;
                if (tx_ready) begin
                    if (mem_select_reg == last_reg) begin
                        state_next = S_FIN;
                    end else begin
                        mem_select_next = mem_select_reg + 1'b1;
                        mem_addr_next   = '0;
                        cks_next        = 8'h00;
                        state_next      = S_SYNC;
                    end
                end
            end
            S_FIN: begin
                done       = 1'b1;
                err        = err_reg;
                err_next   = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: BRAM model with junk outside the read slot,
// table of dump requests, plus reset/restart/latency corner sequences.
module tb_mem_dump_streamer;

    localparam int MSB = 5;
    localparam int AB  = 8;
    localparam int NB  = 30;
    localparam int LAT = 2;

    typedef logic [7:0] byte_t;

    typedef struct {
        int f;
        int l;
        int pct;
        int exp_err;
        int exp_bytes;
        int exp_rd;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [MSB-1:0] first_block = '0;
    logic [MSB-1:0] last_block = '0;
    logic           busy, done, err;
    logic [MSB-1:0] mem_select;
    logic [AB-1:0]  mem_addr;
    logic           rd_en;
    logic [15:0]    mem_out;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b0;

    always #5 clk = ~clk;

    mem_dump_streamer #(
        .MEM_SELECT_BITS(MSB),
        .ADDR_BITS      (AB),
        .DATA_BITS      (16),
        .NUM_BLOCKS     (NB),
        .RD_LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_block(first_block),
        .last_block (last_block),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_select (mem_select),
        .mem_addr   (mem_addr),
        .rd_en      (rd_en),
        .mem_out    (mem_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    function automatic logic [15:0] word_of(input logic [4:0] b, input logic [7:0] i);
        logic [7:0] bb;
        bb = {3'b000, b};
        if (b == 5'd3) return {i, i};
        return {i ^ bb, i + bb};
    endfunction

    // BRAM model: data is only valid exactly LAT cycles after rd_en, junk otherwise.
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [12:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        v1 <= rd_en;
        a1 <= {mem_select, mem_addr};
        v2 <= v1;
        a2 <= a1;
    end
    assign mem_out = v2 ? word_of(a2[12:8], a2[7:0]) : 16'hDEAD;

    int checks = 0;
    int errors = 0;

    byte_t got[$];
    byte_t exp_q[$];
    int rd_cnt, done_cnt, err_cnt, unstable, timed_out, idle_act;
    int s_busy, s_valid, s_data, s_done, s_err;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic build_exp(input int f, input int l);
        byte_t c;
        byte_t hi, lo;
        logic [15:0] w;
        exp_q.delete();
        if (f > l || l >= NB) return;
        for (int b = f; b <= l; b++) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(byte_t'(b));
            c = 8'h00;
            for (int i = 0; i < 256; i++) begin
                w  = word_of(5'(b), 8'(i));
                hi = w[15:8];
                lo = w[7:0];
                exp_q.push_back(hi);
                exp_q.push_back(lo);
                c = c ^ hi ^ lo;
            end
            exp_q.push_back(c);
        end
    endtask

    function automatic int first_mismatch();
        for (int i = 0; i < got.size(); i++) begin
            if (i >= exp_q.size()) return i;
            if (got[i] !== exp_q[i]) return i;
        end
        if (got.size() < exp_q.size()) return got.size();
        return -1;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic run_dump(input int f, input int l, input int pct,
                            input int restart_at, input int stop_after);
        bit    hold;
        byte_t hold_data;
        bit    finished;
        got.delete();
        rd_cnt = 0; done_cnt = 0; err_cnt = 0; unstable = 0; timed_out = 0; idle_act = 0;
        hold = 0; hold_data = 0; finished = 0;
        first_block = 5'(f);
        last_block  = 5'(l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_busy = int'(busy); s_valid = int'(tx_valid); s_data = int'(tx_data);
        s_done = int'(done); s_err = int'(err);
        for (int cyc = 0; cyc < 30000; cyc++) begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (rd_en) rd_cnt++;
            if (hold && (!tx_valid || tx_data !== hold_data)) unstable++;
            if (cyc == restart_at) begin
                first_block = 5'd0;
                last_block  = 5'd0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tx_ready = ($urandom_range(99) < pct);
            if (tx_valid && tx_ready) got.push_back(tx_data);
            hold      = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (done) begin
                finished = 1;
                break;
            end
            if (stop_after > 0 && got.size() == stop_after) begin
                finished = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!finished) timed_out = 1;
        if (finished && stop_after == 0) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (tx_valid || busy || rd_en || done) idle_act++;
            end
        end
    endtask

    vec_t vecs[6];
    int   n, bad;

    initial begin
        vecs[0] = '{f: 3,  l: 3,  pct: 100, exp_err: 0, exp_bytes: 515,  exp_rd: 256};
        vecs[1] = '{f: 2,  l: 1,  pct: 100, exp_err: 1, exp_bytes: 0,    exp_rd: 0};
        vecs[2] = '{f: 0,  l: 30, pct: 100, exp_err: 1, exp_bytes: 0,    exp_rd: 0};
        vecs[3] = '{f: 28, l: 29, pct: 100, exp_err: 0, exp_bytes: 1030, exp_rd: 512};
        vecs[4] = '{f: 3,  l: 3,  pct: 30,  exp_err: 0, exp_bytes: 515,  exp_rd: 256};
        vecs[5] = '{f: 31, l: 31, pct: 100, exp_err: 1, exp_bytes: 0,    exp_rd: 0};

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_mem_select", int'(mem_select), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            build_exp(vecs[v].f, vecs[v].l);
            run_dump(vecs[v].f, vecs[v].l, vecs[v].pct, -1, 0);
            $display("vec %0d: first=%0d last=%0d ready%%=%0d bytes=%0d rd=%0d done=%0d err=%0d",
                     v, vecs[v].f, vecs[v].l, vecs[v].pct, got.size(), rd_cnt, done_cnt, err_cnt);
            check($sformatf("v%0d_start_busy", v), s_busy, 1 - vecs[v].exp_err);
            check($sformatf("v%0d_start_valid", v), s_valid, 1 - vecs[v].exp_err);
            check($sformatf("v%0d_start_done", v), s_done, vecs[v].exp_err);
            check($sformatf("v%0d_start_err", v), s_err, vecs[v].exp_err);
            if (vecs[v].exp_err == 0) check($sformatf("v%0d_first_byte", v), s_data, 'hA5);
            check($sformatf("v%0d_timeout", v), timed_out, 0);
            check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d_err_cnt", v), err_cnt, vecs[v].exp_err);
            check($sformatf("v%0d_nbytes", v), got.size(), vecs[v].exp_bytes);
            check($sformatf("v%0d_stream_mismatch_at", v), first_mismatch(), -1);
            check($sformatf("v%0d_rd_cnt", v), rd_cnt, vecs[v].exp_rd);
            check($sformatf("v%0d_unstable", v), unstable, 0);
            check($sformatf("v%0d_idle_after", v), idle_act, 0);
        end

        // Reset after 100 bytes abandons the frame; a new start replays it from 0xA5.
        run_dump(3, 3, 100, -1, 100);
        reset = 1'b1;
        @(negedge clk);
        $display("midreset: bytes before reset=%0d tx_valid=%0d busy=%0d rd_en=%0d",
                 got.size(), tx_valid, busy, rd_en);
        check("midrst_bytes", got.size(), 100);
        check("midrst_tx_valid", int'(tx_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rd_en", int'(rd_en), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_mem_select", int'(mem_select), 0);
        reset = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        build_exp(3, 3);
        run_dump(3, 3, 100, -1, 0);
        $display("post-reset dump: bytes=%0d done=%0d", got.size(), done_cnt);
        check("redump_stream_mismatch_at", first_mismatch(), -1);
        check("redump_done_cnt", done_cnt, 1);

        // start pulsed while busy is ignored.
        build_exp(28, 28);
        run_dump(28, 28, 60, 50, 0);
        $display("restart-ignored: bytes=%0d rd=%0d done=%0d idle_act=%0d",
                 got.size(), rd_cnt, done_cnt, idle_act);
        check("restart_stream_mismatch_at", first_mismatch(), -1);
        check("restart_done_cnt", done_cnt, 1);
        check("restart_rd_cnt", rd_cnt, 256);
        check("restart_idle_after", idle_act, 0);

        // rd_en to first data byte takes RD + LAT wait cycles, address parked throughout.
        first_block = 5'd5;
        last_block  = 5'd5;
        tx_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lat_rd_seen", int'(rd_en), 1);
        n = 0;
        bad = 0;
        while (!tx_valid && n < 20) begin
            if (mem_select !== 5'd5 || mem_addr !== 8'd0) bad++;
            @(negedge clk);
            n++;
        end
        $display("latency: rd_en to hi byte=%0d cycles, first hi=0x%0h", n, tx_data);
        check("lat_rd_to_hi", n, LAT + 1);
        check("lat_addr_moved", bad, 0);
        check("lat_hi_byte", int'(tx_data), 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
